// File: rtl/eth_tx_arb_if.sv
// Source-side and eth_tx-side bundles for the packet-granular transmit arbiter.
// Signal names keep their arbiter-facing direction suffix on both sides.
interface eth_tx_arb_src_if #(
    parameter int N_SRC     = 2,
    parameter int DATA_W    = 16,
    parameter int LEN_W     = 2,
    parameter int PKT_LEN_W = 16,
    parameter int UDP_CS_W  = 16
);
    logic [N_SRC-1:0]           src_req_i;
    logic [N_SRC-1:0]           src_valid_i;
    logic [N_SRC*DATA_W-1:0]    src_data_i;
    logic [N_SRC*LEN_W-1:0]     src_len_i;
    logic [N_SRC*PKT_LEN_W-1:0] src_pkt_len_i;
    logic [N_SRC*UDP_CS_W-1:0]  src_cs_i;
    logic [N_SRC-1:0]           src_grant_o;
    logic [N_SRC-1:0]           src_ready_o;

    modport master (
        output src_req_i, src_valid_i, src_data_i, src_len_i, src_pkt_len_i, src_cs_i,
        input  src_grant_o, src_ready_o
    );

    modport slave (
        input  src_req_i, src_valid_i, src_data_i, src_len_i, src_pkt_len_i, src_cs_i,
        output src_grant_o, src_ready_o
    );
endinterface

interface eth_tx_arb_app_if #(
    parameter int DATA_W    = 16,
    parameter int LEN_W     = 2,
    parameter int PKT_LEN_W = 16,
    parameter int UDP_CS_W  = 16
);
    logic                 tx_ready_i;
    logic                 app_valid_o;
    logic [DATA_W-1:0]    app_data_o;
    logic [LEN_W-1:0]     app_len_o;
    logic [PKT_LEN_W-1:0] app_pkt_len_o;
    logic [UDP_CS_W-1:0]  app_cs_o;

    modport master (
        output app_valid_o, app_data_o, app_len_o, app_pkt_len_o, app_cs_o,
        input  tx_ready_i
    );

    modport slave (
        input  app_valid_o, app_data_o, app_len_o, app_pkt_len_o, app_cs_o,
        output tx_ready_i
    );
endinterface

// File: rtl/eth_tx_arb.sv
// Round-robin, packet-granular arbiter feeding one eth_tx app interface.
// A grant is held until pkt_len bytes have moved, followed by GAP_CYC idle cycles.
module eth_tx_arb #(
    parameter int N_SRC     = 2,
    parameter int DATA_W    = 16,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int LEN_W     = $clog2(KEEP_W + 1),
    parameter int PKT_LEN_W = 16,
    parameter int UDP_CS_W  = 16,
    parameter int GAP_CYC   = 2
) (
    input  logic             clk,
    input  logic             nreset,
    eth_tx_arb_src_if.slave  src,
    eth_tx_arb_app_if.master app,
    output logic             busy_o,
    output logic             err_o
);

    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [N_SRC-1:0]     grant_q, grant_d;
    logic [SRC_W-1:0]     gidx_q, gidx_d;
    logic [SRC_W-1:0]     rr_q, rr_d;
    logic [PKT_LEN_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [PKT_LEN_W-1:0] plen_q, plen_d;
    logic [UDP_CS_W-1:0]  cs_q, cs_d;
    logic                 err_q, err_d;

    logic                 win_found;
    logic [SRC_W-1:0]     win_idx;
    logic [PKT_LEN_W-1:0] win_plen;
    logic [UDP_CS_W-1:0]  win_cs;

    logic                 in_send;
    logic                 g_valid;
    logic [DATA_W-1:0]    g_data;
    logic [LEN_W-1:0]     g_len;
    logic [PKT_LEN_W-1:0] g_len_ext;
    logic                 xfer;

    // First requester at or after the round-robin pointer, searched cyclically.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!win_found && src.src_req_i[SRC_W'((int'(rr_q) + i) % N_SRC)]) begin
                win_found = 1'b1;
                win_idx   = SRC_W'((int'(rr_q) + i) % N_SRC);
            end
        end
    end

    assign win_plen = src.src_pkt_len_i[int'(win_idx)*PKT_LEN_W +: PKT_LEN_W];
    assign win_cs   = src.src_cs_i[int'(win_idx)*UDP_CS_W +: UDP_CS_W];

    assign g_valid   = src.src_valid_i[gidx_q];
    assign g_data    = src.src_data_i[int'(gidx_q)*DATA_W +: DATA_W];
    assign g_len     = src.src_len_i[int'(gidx_q)*LEN_W +: LEN_W];
    assign g_len_ext = PKT_LEN_W'(g_len);

    // Outputs are forced quiet while reset is held, even before the reset edge lands.
    assign in_send = (state_q == SEND) && !nreset;
    assign xfer    = in_send && g_valid && app.tx_ready_i;

    always_comb begin
        app.app_valid_o   = in_send && g_valid;
        app.app_data_o    = in_send ? g_data : '0;
        app.app_len_o     = in_send ? g_len : '0;
        app.app_pkt_len_o = in_send ? plen_q : '0;
        app.app_cs_o      = in_send ? cs_q : '0;
        src.src_ready_o   = '0;
        if (in_send) begin
            src.src_ready_o[gidx_q] = app.tx_ready_i;
        end
    end

    assign src.src_grant_o = grant_q;
    assign busy_o          = (state_q != IDLE);
    assign err_o           = err_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        plen_d  = plen_q;
        cs_d    = cs_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    rr_d   = SRC_W'((int'(win_idx) + 1) % N_SRC);
                    plen_d = win_plen;
                    cs_d   = win_cs;
                    if (win_plen == '0) begin
                        // Zero-length request is dropped without ever raising a grant.
                        err_d   = 1'b1;
                        gap_d   = GAP_LOAD;
                        state_d = (GAP_CYC == 0) ? IDLE : GAP;
                    end else begin
                        grant_d = {{(N_SRC-1){1'b0}}, 1'b1} << win_idx;
                        gidx_d  = win_idx;
                        rem_d   = win_plen;
                        state_d = SEND;
                    end
                end
            end

            SEND: begin
                if (xfer) begin
                    if (g_len_ext == '0) begin
                        err_d = 1'b1;
                    end else if (g_len_ext >= rem_q) begin
                        // Compare precedes subtract so the counter never wraps on an overrun.
                        err_d   = (g_len_ext > rem_q);
                        rem_d   = '0;
                        grant_d = '0;
                        gap_d   = GAP_LOAD;
                        state_d = (GAP_CYC == 0) ? IDLE : GAP;
                    end else begin
                        rem_d = rem_q - g_len_ext;
                    end
                end
            end

            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            plen_q  <= '0;
            cs_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            plen_q  <= plen_d;
            cs_q    <= cs_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: per-cycle vector table plus sequences for
// backpressure, reset during a packet and sustained two-source contention.
module tb_eth_tx_arb;

    localparam logic [15:0] CS0 = 16'h1234;
    localparam logic [15:0] CS1 = 16'h4321;

    logic clk = 1'b0;
    logic nreset;
    logic busy;
    logic err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    eth_tx_arb_src_if #(.N_SRC(2), .DATA_W(16), .LEN_W(2), .PKT_LEN_W(16), .UDP_CS_W(16)) sif ();
    eth_tx_arb_app_if #(.DATA_W(16), .LEN_W(2), .PKT_LEN_W(16), .UDP_CS_W(16)) aif ();

    eth_tx_arb #(
        .N_SRC(2), .DATA_W(16), .PKT_LEN_W(16), .UDP_CS_W(16), .GAP_CYC(2)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .src    (sif),
        .app    (aif),
        .busy_o (busy),
        .err_o  (err)
    );

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  vld;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  l0;
        logic [1:0]  l1;
        logic [15:0] pl0;
        logic [15:0] pl1;
        logic        tx;
        logic [1:0]  g;
        logic [1:0]  rdy;
        logic        av;
        logic [15:0] ad;
        logic [1:0]  al;
        logic [15:0] apl;
        logic [15:0] acs;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t tbl[30];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] vld,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [1:0] l0, input logic [1:0] l1,
                         input logic [15:0] pl0, input logic [15:0] pl1, input logic tx);
        sif.src_req_i     = req;
        sif.src_valid_i   = vld;
        sif.src_data_i    = {d1, d0};
        sif.src_len_i     = {l1, l0};
        sif.src_pkt_len_i = {pl1, pl0};
        sif.src_cs_i      = {CS1, CS0};
        aif.tx_ready_i    = tx;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_own[4];
        int bytes, beats, ncyc, pk, idle, nb, own;
        logic done;
        logic [1:0] g, prev_g;

        //            req    vld    d0        d1        l0    l1    pl0     pl1     tx    g      rdy    av    ad        al    apl     acs    busy  err
        tbl[0]  = '{2'b01, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd5, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b0, 1'b0};
        tbl[1]  = '{2'b01, 2'b11, 16'hA001, 16'hB001, 2'd2, 2'd2, 16'd5, 16'd0, 1'b1, 2'b01, 2'b01, 1'b1, 16'hA001, 2'd2, 16'd5, CS0,   1'b1, 1'b0};
        tbl[2]  = '{2'b01, 2'b11, 16'hA002, 16'hB002, 2'd2, 2'd2, 16'd9, 16'd0, 1'b1, 2'b01, 2'b01, 1'b1, 16'hA002, 2'd2, 16'd5, CS0,   1'b1, 1'b0};
        tbl[3]  = '{2'b01, 2'b11, 16'hA003, 16'hB003, 2'd1, 2'd2, 16'd9, 16'd0, 1'b1, 2'b01, 2'b01, 1'b1, 16'hA003, 2'd1, 16'd5, CS0,   1'b1, 1'b0};
        tbl[4]  = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b1, 1'b0};
        tbl[5]  = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b1, 1'b0};
        tbl[6]  = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b0, 1'b0};
        tbl[7]  = '{2'b01, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd3, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b0, 1'b0};
        tbl[8]  = '{2'b01, 2'b01, 16'hC001, 16'h0000, 2'd2, 2'd0, 16'd3, 16'd0, 1'b1, 2'b01, 2'b01, 1'b1, 16'hC001, 2'd2, 16'd3, CS0,   1'b1, 1'b0};
        tbl[9]  = '{2'b00, 2'b01, 16'hC002, 16'h0000, 2'd2, 2'd0, 16'd3, 16'd0, 1'b1, 2'b01, 2'b01, 1'b1, 16'hC002, 2'd2, 16'd3, CS0,   1'b1, 1'b0};
        tbl[10] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b1, 1'b1};
        tbl[11] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b1, 1'b0};
        tbl[12] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b0, 1'b0};
        tbl[13] = '{2'b10, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b0, 1'b0};
        tbl[14] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b1, 1'b1};
        tbl[15] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b1, 1'b0};
        tbl[16] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b0, 1'b0};
        tbl[17] = '{2'b11, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd2, 16'd2, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b0, 1'b0};
        tbl[18] = '{2'b11, 2'b11, 16'hD001, 16'hE001, 2'd2, 2'd2, 16'd2, 16'd2, 1'b1, 2'b01, 2'b01, 1'b1, 16'hD001, 2'd2, 16'd2, CS0,   1'b1, 1'b0};
        tbl[19] = '{2'b11, 2'b00, 16'h0000, 16'h0000, 2'd2, 2'd2, 16'd2, 16'd2, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b1, 1'b0};
        tbl[20] = '{2'b11, 2'b00, 16'h0000, 16'h0000, 2'd2, 2'd2, 16'd2, 16'd2, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b1, 1'b0};
        tbl[21] = '{2'b11, 2'b00, 16'h0000, 16'h0000, 2'd2, 2'd2, 16'd2, 16'd2, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b0, 1'b0};
        tbl[22] = '{2'b11, 2'b11, 16'hD002, 16'hE002, 2'd2, 2'd2, 16'd2, 16'd2, 1'b1, 2'b10, 2'b10, 1'b1, 16'hE002, 2'd2, 16'd2, CS1,   1'b1, 1'b0};
        tbl[23] = '{2'b11, 2'b00, 16'h0000, 16'h0000, 2'd2, 2'd2, 16'd2, 16'd2, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b1, 1'b0};
        tbl[24] = '{2'b11, 2'b00, 16'h0000, 16'h0000, 2'd2, 2'd2, 16'd2, 16'd2, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b1, 1'b0};
        tbl[25] = '{2'b11, 2'b00, 16'h0000, 16'h0000, 2'd2, 2'd2, 16'd2, 16'd2, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b0, 1'b0};
        tbl[26] = '{2'b11, 2'b11, 16'hD003, 16'hE003, 2'd2, 2'd2, 16'd2, 16'd2, 1'b1, 2'b01, 2'b01, 1'b1, 16'hD003, 2'd2, 16'd2, CS0,   1'b1, 1'b0};
        tbl[27] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b1, 1'b0};
        tbl[28] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b1, 1'b0};
        tbl[29] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 16'h0000, 2'd0, 16'd0, 16'h0, 1'b0, 1'b0};

        // Reset with requests and valids active: everything must stay quiet.
        nreset = 1'b1;
        drive(2'b11, 2'b11, 16'h5555, 16'h6666, 2'd2, 2'd2, 16'd4, 16'd4, 1'b1);
        tick;
        tick;
        @(negedge clk);
        chk("rst_grant", 32'(sif.src_grant_o), 32'h0);
        chk("rst_ready", 32'(sif.src_ready_o), 32'h0);
        chk("rst_valid", 32'(aif.app_valid_o), 32'h0);
        chk("rst_data",  32'(aif.app_data_o), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_err",   32'(err), 32'h0);
        tick;
        nreset = 1'b0;

        // Per-cycle vectors: single packet, isolation, overrun, zero length, alternation.
        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].req, tbl[i].vld, tbl[i].d0, tbl[i].d1, tbl[i].l0, tbl[i].l1,
                  tbl[i].pl0, tbl[i].pl1, tbl[i].tx);
            @(negedge clk);
            chk($sformatf("row%0d_grant", i),  32'(sif.src_grant_o),   32'(tbl[i].g));
            chk($sformatf("row%0d_ready", i),  32'(sif.src_ready_o),   32'(tbl[i].rdy));
            chk($sformatf("row%0d_valid", i),  32'(aif.app_valid_o),   32'(tbl[i].av));
            chk($sformatf("row%0d_data", i),   32'(aif.app_data_o),    32'(tbl[i].ad));
            chk($sformatf("row%0d_len", i),    32'(aif.app_len_o),     32'(tbl[i].al));
            chk($sformatf("row%0d_pktlen", i), 32'(aif.app_pkt_len_o), 32'(tbl[i].apl));
            chk($sformatf("row%0d_cs", i),     32'(aif.app_cs_o),      32'(tbl[i].acs));
            chk($sformatf("row%0d_busy", i),   32'(busy),              32'(tbl[i].busy));
            chk($sformatf("row%0d_err", i),    32'(err),               32'(tbl[i].err));
            tick;
        end

        // Backpressure: pkt_len 6 in 2-byte beats, tx_ready low for 3 cycles after beat 0.
        drive(2'b01, 2'b00, 16'h0, 16'h0, 2'd0, 2'd0, 16'd6, 16'd0, 1'b1);
        tick;
        bytes = 0;
        beats = 0;
        ncyc  = 0;
        done  = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            drive(2'b00, 2'b01, 16'hF000 + 16'(beats), 16'h0, 2'd2, 2'd0, 16'd0, 16'd0,
                  (c >= 1 && c <= 3) ? 1'b0 : 1'b1);
            @(negedge clk);
            if (c == 0) chk("bp_grant", 32'(sif.src_grant_o), 32'h1);
            chk("bp_ready",  32'(sif.src_ready_o), 32'(aif.tx_ready_i));
            chk("bp_data",   32'(aif.app_data_o), 32'(16'hF000 + 16'(beats)));
            chk("bp_pktlen", 32'(aif.app_pkt_len_o), 32'd6);
            chk("bp_err",    32'(err), 32'h0);
            if (aif.app_valid_o && aif.tx_ready_i) begin
                bytes += int'(aif.app_len_o);
                beats++;
            end
            ncyc++;
            tick;
            if (sif.src_grant_o == 2'b00) done = 1'b1;
        end
        drive(2'b00, 2'b00, 16'h0, 16'h0, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1);
        chk("bp_done",   32'(done), 32'h1);
        chk("bp_bytes",  32'(bytes), 32'd6);
        chk("bp_beats",  32'(beats), 32'd3);
        chk("bp_cycles", 32'(ncyc), 32'd6);
        tick;
        tick;
        tick;

        // Reset asserted during the second beat of a packet.
        drive(2'b01, 2'b00, 16'h0, 16'h0, 2'd0, 2'd0, 16'd4, 16'd0, 1'b1);
        tick;
        drive(2'b01, 2'b01, 16'h1111, 16'h0, 2'd2, 2'd0, 16'd4, 16'd0, 1'b1);
        @(negedge clk);
        chk("rs_beat1", 32'(aif.app_valid_o), 32'h1);
        tick;
        drive(2'b01, 2'b01, 16'h2222, 16'h0, 2'd2, 2'd0, 16'd4, 16'd0, 1'b1);
        nreset = 1'b1;
        @(negedge clk);
        chk("rs_hold_valid", 32'(aif.app_valid_o), 32'h0);
        chk("rs_hold_ready", 32'(sif.src_ready_o), 32'h0);
        tick;
        nreset = 1'b0;
        drive(2'b00, 2'b00, 16'h0, 16'h0, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1);
        @(negedge clk);
        chk("rs_busy",  32'(busy), 32'h0);
        chk("rs_grant", 32'(sif.src_grant_o), 32'h0);
        chk("rs_valid", 32'(aif.app_valid_o), 32'h0);
        chk("rs_err",   32'(err), 32'h0);
        tick;
        drive(2'b11, 2'b00, 16'h0, 16'h0, 2'd0, 2'd0, 16'd2, 16'd2, 1'b1);
        tick;
        drive(2'b00, 2'b01, 16'h3333, 16'h0, 2'd2, 2'd0, 16'd2, 16'd2, 1'b1);
        @(negedge clk);
        chk("rs_regrant", 32'(sif.src_grant_o), 32'h1);
        chk("rs_data",    32'(aif.app_data_o), 32'h3333);
        tick;
        drive(2'b00, 2'b00, 16'h0, 16'h0, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1);
        @(negedge clk);
        chk("rs_release", 32'(sif.src_grant_o), 32'h0);
        tick;
        tick;
        tick;

        // Sustained contention: pointer is at 1, so grants run 1,0,1,0.
        exp_own[0] = 1;
        exp_own[1] = 0;
        exp_own[2] = 1;
        exp_own[3] = 0;
        pk     = 0;
        idle   = 0;
        nb     = 0;
        prev_g = 2'b00;
        drive(2'b11, 2'b11, 16'hAA00, 16'hBB00, 2'd2, 2'd2, 16'd4, 16'd4, 1'b1);
        for (int c = 0; c < 80 && pk < 4; c++) begin
            @(negedge clk);
            g = sif.src_grant_o;
            chk("ct_err", 32'(err), 32'h0);
            if (g != 2'b00) begin
                own = (g == 2'b10) ? 1 : 0;
                if (prev_g == 2'b00) begin
                    chk("ct_grant", 32'(g), 32'(2'b01 << exp_own[pk]));
                    if (pk > 0) chk("ct_gap", 32'(idle), 32'd3);
                    idle = 0;
                    nb   = 0;
                end
                if (aif.app_valid_o) begin
                    nb++;
                    chk("ct_data", 32'(aif.app_data_o), (own == 1) ? 32'h0000BB00 : 32'h0000AA00);
                end
            end else begin
                if (prev_g != 2'b00) begin
                    chk("ct_beats", 32'(nb), 32'd2);
                    pk++;
                end
                idle++;
            end
            prev_g = g;
            tick;
        end
        chk("ct_pkts", 32'(pk), 32'd4);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 2'd0, 2'd0, 16'd0, 16'd0, 1'b1);
        repeat (4) tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
